// File: rtl/z_event_counter.sv
// z_event_counter: counts rising events on z in two BCD digits. Counting saturates at
// MAX_COUNT, with a sticky overflow flag. A two-state edge FSM gives exactly one event
// per z high pulse.
module z_event_counter #(
   parameter int unsigned MAX_COUNT = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       z,
   input  logic       en,
   input  logic       clr,
   output logic [3:0] count_ones,
   output logic [3:0] count_tens,
   output logic       hit,
   output logic       ovf,
   output logic       edge_state
);

   typedef enum logic {
      StWaitLow = 1'b0,
      StArmed   = 1'b1
   } state_e;

   localparam logic [3:0] MaxTens = 4'(MAX_COUNT / 10);
   localparam logic [3:0] MaxOnes = 4'(MAX_COUNT % 10);

   state_e     r_state, w_state_d;
   logic [3:0] r_ones, w_ones_d;
   logic [3:0] r_tens, w_tens_d;
   logic       r_hit, w_hit_d;
   logic       r_ovf, w_ovf_d;
   logic       w_event;
   logic       w_at_max;

   // An event is z seen high while armed, i.e. after z was sampled low.
   assign w_event  = (r_state == StArmed) && z;
   assign w_at_max = (r_tens == MaxTens) && (r_ones == MaxOnes);

   // Edge FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StWaitLow;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Edge FSM next state; ignores en and clr so a suppressed event is still consumed.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StWaitLow: if (!z) w_state_d = StArmed;
         StArmed:   if (z)  w_state_d = StWaitLow;
         default:   w_state_d = StWaitLow;
      endcase
   end

   // Count, hit and overflow next state; clr wins over a coincident event.
   always_comb begin
      w_ones_d = r_ones;
      w_tens_d = r_tens;
      w_ovf_d  = r_ovf;
      w_hit_d  = 1'b0;
      if (clr) begin
         w_ones_d = 4'd0;
         w_tens_d = 4'd0;
         w_ovf_d  = 1'b0;
      end else if (w_event && en) begin
         w_hit_d = 1'b1;
         if (w_at_max) begin
            w_ovf_d = 1'b1;
         end else if (r_ones == 4'd9) begin
            w_ones_d = 4'd0;
            w_tens_d = r_tens + 4'd1;
         end else begin
            w_ones_d = r_ones + 4'd1;
         end
      end
   end

   // Count, hit and overflow registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ones <= 4'd0;
         r_tens <= 4'd0;
         r_hit  <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_ones <= w_ones_d;
         r_tens <= w_tens_d;
         r_hit  <= w_hit_d;
         r_ovf  <= w_ovf_d;
      end
   end

   assign count_ones = r_ones;
   assign count_tens = r_tens;
   assign hit        = r_hit;
   assign ovf        = r_ovf;
   assign edge_state = r_state;

endmodule
